// File: rtl/wb_port_arbiter.sv
// Purpose: shares the register-file write port between the pipeline and a FIFO of multi-cycle results.
// Latency: pipeline writes same cycle; multi-cycle writes >= 1 cycle after acceptance (0 with bypass).
// Backpressure: mc_ready drops when the FIFO is full; pipe_stall asserts on a forced drain of a starved head.
// Optional feature macro: WB_PORT_ARBITER_BYPASS_EN (empty-FIFO same-cycle write of an idle-slot mc result).
module wb_port_arbiter #(
  parameter int N        = 32,
  parameter int A        = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [A-1:0]             pipe_rd,
  input  logic                     pipe_wd_sel,
  input  logic [N-1:0]             pipe_read_data,
  input  logic [N-1:0]             pipe_alu_result,
  output logic                     pipe_stall,
  input  logic                     mc_valid,
  input  logic [A-1:0]             mc_rd,
  input  logic [N-1:0]             mc_data,
  output logic                     mc_ready,
  output logic                     rf_we,
  output logic [A-1:0]             rf_wa,
  output logic [N-1:0]             rf_wd,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  // One buffered multi-cycle result; live drops when a younger pipeline write hits the same rd.
  typedef struct packed {
    logic         live;
    logic [A-1:0] rd;
    logic [N-1:0] data;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wait_cnt;

  entry_t          head;
  logic            empty;
  logic            full;
  logic            head_live;
  logic            forced;
  logic [N-1:0]    pipe_wd;
  logic            sel_we;
  logic [A-1:0]    sel_wa;
  logic [N-1:0]    sel_wd;
  logic            pop;
  logic            push;
  logic            bypass;
  logic            pipe_commit;

  assign head      = fifo_q[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_live = !empty && head.live;
  assign forced    = head_live && (wait_cnt == WW'(MAX_WAIT));
  assign pipe_wd   = pipe_wd_sel ? pipe_alu_result : pipe_read_data;

  // Port decision: forced drain, then pipeline, then live head; a killed head always pops for free.
  always_comb begin
    sel_we     = 1'b0;
    sel_wa     = '0;
    sel_wd     = '0;
    pop        = 1'b0;
    pipe_stall = 1'b0;
    bypass     = 1'b0;
    if (rst) begin
      if (forced) begin
        pipe_stall = 1'b1;
        sel_we     = 1'b1;
        sel_wa     = head.rd;
        sel_wd     = head.data;
        pop        = 1'b1;
      end else if (pipe_we) begin
        sel_we = 1'b1;
        sel_wa = pipe_rd;
        sel_wd = pipe_wd;
        pop    = !empty && !head.live;
      end else if (head_live) begin
        sel_we = 1'b1;
        sel_wa = head.rd;
        sel_wd = head.data;
        pop    = 1'b1;
      end else if (!empty) begin
        pop = 1'b1;
`ifdef WB_PORT_ARBITER_BYPASS_EN
      end else if (mc_valid) begin
        bypass = 1'b1;
        sel_we = 1'b1;
        sel_wa = mc_rd;
        sel_wd = mc_data;
`endif
      end
    end
  end

  // x0 is hard-wired: the slot is consumed but nothing is written.
  assign rf_we       = sel_we && (sel_wa != '0);
  assign rf_wa       = sel_wa;
  assign rf_wd       = sel_wd;
  assign mc_ready    = rst && !full;
  assign push        = mc_valid && mc_ready && !bypass;
  assign pipe_commit = rst && pipe_we && !forced;
  assign fifo_count  = count;

  // FIFO storage, kill flags and pointers; a same-cycle push is younger than the killing pipeline write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pipe_commit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fifo_q[i].rd == pipe_rd) begin
            fifo_q[i].live <= 1'b0;
          end
        end
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{live: 1'b1, rd: mc_rd, data: mc_data};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter for the head: counts undrained live cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (pop || empty) begin
      wait_cnt <= '0;
    end else if (head_live && (wait_cnt != WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule
